// File: rtl/mem_arb_pkg.sv
// Shared sizes and FSM state encoding for the two-requester memory arbiter.
package mem_arb_pkg;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int DW      = 8;
  localparam int NUM_REQ = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/mem_arb_if.sv
// Request/response bundle between the two requesters (master) and mem_arb (slave).
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic          req0_valid, req0_we, req0_ready;
  logic [AW:0]   req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          rsp0_valid, rsp0_err;
  logic [DW-1:0] rsp0_rdata;

  logic          req1_valid, req1_we, req1_ready;
  logic [AW:0]   req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp1_valid, rsp1_err;
  logic [DW-1:0] rsp1_rdata;

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err
  );

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err
  );
endinterface

// File: rtl/mem_arb_rf.sv
// 8x8 storage: one synchronous write port, one registered read port.
module mem_arb_rf
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Contents are established by the arbiter's init sweep, so no reset here.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter for two requesters sharing mem_arb_rf, with an INIT sweep.
// MEM_ARB_OOR_ERR_EN: flag addr[3]=1 requests as errors instead of wrapping.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter logic [DW-1:0] INIT_VAL = 8'h00
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_arb_if.slave bus,
  output logic     init_done
);
  logic [NUM_REQ-1:0]         valid, we, ready, rsp_vld_q, rsp_vld_d;
  logic [NUM_REQ-1:0][AW:0]   addr;
  logic [NUM_REQ-1:0][DW-1:0] wdata;
  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d, gnt, acc, oor, sel_we;
  logic [AW:0]   sel_addr;
  logic [DW-1:0] sel_wdata, rf_wdata, rf_rdata, rd_data;
  logic [AW-1:0] rf_waddr;
  logic          rf_we, rsp_rd_q, rsp_rd_d, rsp_oor_q, rsp_oor_d;

  assign valid = {bus.req1_valid, bus.req0_valid};
  assign we    = {bus.req1_we,    bus.req0_we};
  assign addr  = {bus.req1_addr,  bus.req0_addr};
  assign wdata = {bus.req1_wdata, bus.req0_wdata};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(DEPTH-1)) state_d = ST_RUN;
    end
  end

  // Tie goes to the requester not granted last; ready is gated by rst_n so
  // nothing is accepted on an edge that resets the block.
  always_comb begin
    gnt       = (valid[0] && valid[1]) ? ~last_q : valid[1];
    acc       = rst_n && (state_q == ST_RUN) && (|valid);
    ready     = '0;
    if (acc) ready[gnt] = 1'b1;
    last_d    = acc ? gnt : last_q;
    sel_we    = we[gnt];
    sel_addr  = addr[gnt];
    sel_wdata = wdata[gnt];
  end

`ifdef MEM_ARB_OOR_ERR_EN
  assign oor = sel_addr[AW];
`else
  logic unused_addr_msb;
  assign oor             = 1'b0;
  assign unused_addr_msb = sel_addr[AW];
`endif

  assign rf_we     = (state_q == ST_INIT) || (acc && sel_we && !oor);
  assign rf_waddr  = (state_q == ST_INIT) ? cnt_q : sel_addr[AW-1:0];
  assign rf_wdata  = (state_q == ST_INIT) ? INIT_VAL : sel_wdata;
  assign rsp_vld_d = ready;
  assign rsp_rd_d  = ~sel_we;
  assign rsp_oor_d = oor;

  mem_arb_rf u_rf (
    .clk     (clk),
    .we_i    (rf_we),
    .waddr_i (rf_waddr),
    .wdata_i (rf_wdata),
    .re_i    (acc && !sel_we),
    .raddr_i (sel_addr[AW-1:0]),
    .rdata_o (rf_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rsp_vld_q <= '0;
      rsp_rd_q  <= 1'b0;
      rsp_oor_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_oor_q <= rsp_oor_d;
    end
  end

  assign rd_data        = (rsp_rd_q && !rsp_oor_q) ? rf_rdata : '0;
  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.rsp0_valid = rsp_vld_q[0];
  assign bus.rsp1_valid = rsp_vld_q[1];
  assign bus.rsp0_rdata = rsp_vld_q[0] ? rd_data : '0;
  assign bus.rsp1_rdata = rsp_vld_q[1] ? rd_data : '0;
  assign bus.rsp0_err   = rsp_vld_q[0] && rsp_oor_q;
  assign bus.rsp1_err   = rsp_vld_q[1] && rsp_oor_q;
  assign init_done      = (state_q == ST_RUN);
endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: grant table plus directed init/RAW/OOR/reset sequences,
// with a response scoreboard fed from a reference memory model.
module tb_mem_arb;
  localparam logic [7:0] IV = 8'hC3;
`ifdef MEM_ARB_OOR_ERR_EN
  localparam bit OOR = 1'b1;
`else
  localparam bit OOR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_arb_if bus ();
  mem_arb #(.INIT_VAL(IV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .init_done(init_done));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: accepted requests queue their expected response here.
  typedef struct packed { logic id; logic [7:0] rdata; logic err; } exp_t;
  exp_t       sbq[$];
  logic [7:0] mdl [8];
  bit         armed = 1'b0;
  logic [1:0] m_v, m_r, m_rv, m_er, m_we;
  logic [1:0][3:0] m_a;
  logic [1:0][7:0] m_d, m_rd;
  exp_t       m_e;
  logic       m_oor;

  initial forever begin
    @(negedge clk);
    m_v  = {bus.req1_valid, bus.req0_valid};
    m_r  = {bus.req1_ready, bus.req0_ready};
    m_rv = {bus.rsp1_valid, bus.rsp0_valid};
    m_er = {bus.rsp1_err, bus.rsp0_err};
    m_we = {bus.req1_we, bus.req0_we};
    m_a  = {bus.req1_addr, bus.req0_addr};
    m_d  = {bus.req1_wdata, bus.req0_wdata};
    m_rd = {bus.rsp1_rdata, bus.rsp0_rdata};
    if (armed) begin
      for (int n = 0; n < 2; n++) begin
        if (m_rv[n]) begin
          if (sbq.size() == 0 || sbq[0].id != 1'(n)) chk("rsp_spurious", 32'(m_rv[n]), 32'(0));
          else begin
            chk("sb_rdata", 32'(m_rd[n]), 32'(sbq[0].rdata));
            chk("sb_err", 32'(m_er[n]), 32'(sbq[0].err));
            void'(sbq.pop_front());
          end
        end else chk("rsp_idle_zero", 32'({m_rd[n], m_er[n]}), 32'(0));
      end
      chk("rsp_missing", 32'(sbq.size()), 32'(0));
      sbq.delete();
      chk("ready_onehot", 32'(m_r[0] & m_r[1]), 32'(0));
      if (!rst_n) chk("ready_in_reset", 32'(m_r), 32'(0));
      else for (int n = 0; n < 2; n++) begin
        if (m_v[n] && m_r[n]) begin
          m_oor   = OOR && m_a[n][3];
          m_e.id  = 1'(n);
          m_e.err = m_oor;
          m_e.rdata = (m_we[n] || m_oor) ? 8'h00 : mdl[m_a[n][2:0]];
          sbq.push_back(m_e);
          if (m_we[n] && !m_oor) mdl[m_a[n][2:0]] = m_d[n];
        end
      end
    end
    if (!rst_n) begin
      armed = 1'b1;
      sbq.delete();
      foreach (mdl[i]) mdl[i] = IV;
    end
  end

  task automatic setreq(input int n, input logic v, input logic w, input logic [3:0] a,
                        input logic [7:0] d);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_we = w; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = w; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic idle(input int n);
    setreq(n, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_check(input string nm);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk(nm, 32'(init_done), 32'(i == 8));
    end
  endtask

  typedef struct packed {
    logic v0, we0; logic [3:0] a0; logic [7:0] d0;
    logic v1, we1; logic [3:0] a1; logic [7:0] d1;
    logic r0, r1;
  } vec_t;

  initial begin
    vec_t vec [11];
    vec[0]  = '{1'b1, 1'b1, 4'h1, 8'h11, 1'b1, 1'b1, 4'h2, 8'h22, 1'b1, 1'b0};
    vec[1]  = '{1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 1'b1, 4'h2, 8'h22, 1'b0, 1'b1};
    vec[2]  = '{1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 1'b0, 4'h2, 8'h00, 1'b1, 1'b0};
    vec[3]  = '{1'b1, 1'b1, 4'h6, 8'h66, 1'b1, 1'b0, 4'h2, 8'h00, 1'b0, 1'b1};
    vec[4]  = '{1'b1, 1'b1, 4'h6, 8'h66, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h6, 8'h00, 1'b0, 1'b1};
    vec[6]  = '{1'b1, 1'b0, 4'h7, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1};
    vec[8]  = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0};
    vec[9]  = '{1'b1, 1'b1, 4'h0, 8'h5A, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0};
    vec[10] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1};

    idle(0); idle(1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_init_done", 32'(init_done), 32'(0));
    chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'(0));
    chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'(0));

    // Request held through INIT: blocked until the sweep ends, then accepted.
    rst_n = 1'b1;
    setreq(0, 1'b1, 1'b0, 4'h5, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("init_done_sweep", 32'(init_done), 32'(i == 8));
      chk("ready0_in_init", 32'(bus.req0_ready), 32'(i == 8));
    end
    tick(); idle(0);
    @(negedge clk);
    chk("rd_init_valid", 32'(bus.rsp0_valid), 32'(1));
    chk("rd_init_rdata", 32'(bus.rsp0_rdata), 32'(IV));

    // Write then read-after-write from the other requester.
    tick(); setreq(0, 1'b1, 1'b1, 4'h3, 8'hA5);
    @(negedge clk); chk("wr_ready0", 32'(bus.req0_ready), 32'(1));
    tick(); idle(0); setreq(1, 1'b1, 1'b0, 4'h3, 8'h00);
    @(negedge clk);
    chk("wr_rsp_valid", 32'(bus.rsp0_valid), 32'(1));
    chk("wr_rsp_rdata", 32'(bus.rsp0_rdata), 32'(0));
    chk("raw_ready1", 32'(bus.req1_ready), 32'(1));
    tick(); idle(1);
    @(negedge clk);
    chk("raw_rsp_valid", 32'(bus.rsp1_valid), 32'(1));
    chk("raw_rsp_rdata", 32'(bus.rsp1_rdata), 32'(8'hA5));

    tick();
    foreach (vec[k]) begin
      setreq(0, vec[k].v0, vec[k].we0, vec[k].a0, vec[k].d0);
      setreq(1, vec[k].v1, vec[k].we1, vec[k].a1, vec[k].d1);
      @(negedge clk);
      chk("tbl_ready0", 32'(bus.req0_ready), 32'(vec[k].r0));
      chk("tbl_ready1", 32'(bus.req1_ready), 32'(vec[k].r1));
      tick();
    end
    idle(0); idle(1);
    @(negedge clk);

    // Out-of-range address: error flag with the macro, wrap to entry 2 without.
    tick(); setreq(0, 1'b1, 1'b1, 4'hA, 8'h3C);
    @(negedge clk); chk("oor_wr_ready", 32'(bus.req0_ready), 32'(1));
    tick(); setreq(0, 1'b1, 1'b0, 4'h2, 8'h00);
    @(negedge clk); chk("oor_wr_err", 32'(bus.rsp0_err), 32'(OOR));
    tick(); setreq(0, 1'b1, 1'b0, 4'hA, 8'h00);
    @(negedge clk); chk("oor_entry2", 32'(bus.rsp0_rdata), 32'(OOR ? 8'h22 : 8'h3C));
    tick(); idle(0);
    @(negedge clk);
    chk("oor_rd_rdata", 32'(bus.rsp0_rdata), 32'(OOR ? 8'h00 : 8'h3C));
    chk("oor_rd_err", 32'(bus.rsp0_err), 32'(OOR));

    // Reset right after a read accept, then again mid-sweep.
    tick(); setreq(0, 1'b1, 1'b0, 4'h3, 8'h00);
    @(negedge clk); chk("pre_rst_ready0", 32'(bus.req0_ready), 32'(1));
    tick(); rst_n = 1'b0; idle(0);
    @(negedge clk); chk("pre_rst_rdata", 32'(bus.rsp0_rdata), 32'(8'hA5));
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_drop_rsp", 32'(bus.rsp0_valid), 32'(0));
    chk("rst_init_low", 32'(init_done), 32'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    sweep_check("resweep_done");
    for (int a = 0; a < 8; a++) begin
      tick(); setreq(0, 1'b1, 1'b0, 4'(a), 8'h00);
      @(negedge clk); chk("post_rst_ready0", 32'(bus.req0_ready), 32'(1));
    end
    tick(); idle(0);
    @(negedge clk);
    chk("post_rst_last_rdata", 32'(bus.rsp0_rdata), 32'(IV));
    tick();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter INIT_VAL, default 8'h00, the value every storage entry holds after initialisation.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have ports reqN_valid  in  1  request present, for N in {0,1}.
REQ-005 SHALL have ports reqN_we  in  1  1 = write, 0 = read.
REQ-006 SHALL have ports reqN_addr  in  4  entry address; bit 3 is out of range.
REQ-007 SHALL have ports reqN_wdata  in  8  write data.
REQ-008 SHALL have ports reqN_ready  out  1  request accepted this cycle.
REQ-009 SHALL have ports rspN_valid  out  1  one-cycle response strobe.
REQ-010 SHALL have ports rspN_rdata  out  8  read data, 8'h00 for writes.
REQ-011 SHALL have ports rspN_err  out  1  response error flag.
REQ-012 SHALL have port init_done  out  1  high once initialisation sweep completes.

Function
REQ-013 SHALL own an 8-entry x 8-bit storage array shared by requesters 0 and 1.
REQ-014 SHALL implement FSM states INIT and RUN; reset enters INIT with sweep counter 0.
REQ-015 SHALL, in INIT, write INIT_VAL to entry cnt each cycle with cnt 0..7, move to RUN after cnt=7 (8 cycles), and hold both reqN_ready low.
REQ-016 SHALL drive init_done high only in RUN.
REQ-017 SHALL accept at most one request per cycle; a request is accepted when reqN_valid and reqN_ready are both high.
REQ-018 SHALL drive reqN_ready combinationally: in RUN, high for the granted requester only.
REQ-019 SHALL grant the sole valid requester; when both are valid, grant the one not granted last (round-robin); the last-grant pointer resets to 1 so requester 0 wins the first tie.
REQ-020 SHALL update the last-grant pointer only on acceptance.
REQ-021 SHALL commit an accepted write to storage on the accepting edge.
REQ-022 SHALL assert rspN_valid for exactly one cycle, one cycle after acceptance, for reads and writes.
REQ-023 SHALL, for an accepted read, register storage[addr] so it appears on rspN_rdata with rspN_valid (latency 1); a read the cycle after a write to the same address SHALL return the new data.
REQ-024 SHALL hold rspN_rdata and rspN_err at 0 whenever rspN_valid is low.
REQ-025 SHALL accept responses without backpressure; requesters always consume rspN_valid.
REQ-026 SHALL leave request inputs of a non-granted requester unconsumed; that requester holds them until ready.

Reset
REQ-027 SHALL, when rst_n is low at a rising edge, clear reqN_ready, rspN_valid, rspN_rdata, rspN_err, and init_done to 0, enter INIT, and drop any in-flight response.
REQ-028 SHALL restart the full 8-cycle sweep when reset asserts mid-INIT or mid-RUN.

Configuration
REQ-029 SHALL provide macro MEM_ARB_OOR_ERR_EN.
REQ-030 SHALL, with MEM_ARB_OOR_ERR_EN defined, accept requests with addr[3]=1, suppress the write, return rdata 0, and assert rspN_err with the response.
REQ-031 SHALL, without MEM_ARB_OOR_ERR_EN, ignore addr[3] so that address wraps to addr[2:0], and tie rspN_err to 0.

Structure
REQ-032 SHALL place DEPTH=8, AW=3, DW=8, the requester count (2), and the FSM state enum in package mem_arb_pkg.
REQ-033 SHALL instantiate the storage array as sub-module mem_arb_rf, with one synchronous write port and one registered read port; arbitration, FSM, and response logic SHALL stay in mem_arb.

Verification
REQ-034 Reset, then idle 8 cycles -> init_done rises on cycle 9; then read0 addr 5 -> rsp0_rdata=INIT_VAL one cycle after accept.
REQ-035 Write0 addr 3 = 8'hA5, next cycle read1 addr 3 -> rsp0_valid with rdata 0, then rsp1_rdata=8'hA5.
REQ-036 Both valid for 4 consecutive cycles -> grants in order 0,1,0,1, one acceptance per cycle.
REQ-037 Request during INIT -> reqN_ready stays 0 until init_done=1, then accepted.
REQ-038 Write addr 4'hA = 8'h3C -> with macro: rsp_err=1 and entry 2 unchanged; without macro: entry 2 = 8'h3C, rsp_err=0.
REQ-039 rst_n low for 1 cycle right after a read accept -> no rsp_valid, init_done=0, and all entries read INIT_VAL after the new sweep.
